simt_branch_seq: RTL
====================

# simt_branch_seq

Per-warp SIMT branch sequencer for the shader core. It consumes resolved-branch and sequential-advance events from the warp front end. It maintains the warp's current PC, active mask and reconvergence PC, and sequences pushes and pops into a private context stack, so the scheduler always sees the correct `(pc, mask)` to issue next. It sits between the branch unit and the warp scheduler and replaces ad-hoc push/pop wiring to the divergence stack.

## Interface
- `W`, 32: warp width (lanes).
- `PC_W`, 16: PC width.
- `DEPTH`, 8: context-stack entries; must be ≥ 2.
- `CNT_W`, 16: divergence counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: load initial warp context. Honoured only in IDLE.
- `start_pc` in PC_W / `start_mask` in W: initial context. `start_mask` must be non-zero.
- `ev_valid` in 1 / `ev_ready` out 1: event handshake. An event transfers on `ev_valid & ev_ready`.
- `ev_is_br` in 1: 1 means branch event, 0 means sequential step.
- `ev_pc` in PC_W: next sequential PC for a step, or fall-through PC for a branch.
- `ev_target_pc` in PC_W: branch target.
- `ev_reconv_pc` in PC_W: branch reconvergence PC (immediate post-dominator).
- `ev_taken_mask` in W: per-lane taken bits. Bits outside `cur_mask` are ignored.
- `cur_valid` out 1: high in RUN only.
- `cur_pc` out PC_W / `cur_mask` out W: context to issue.
- `depth` out $clog2(DEPTH+1): occupied stack entries.
- `ovf` out 1: sticky stack-overflow error.
- `div_count` out CNT_W: divergent branches accepted. Saturating.

## Operation
- States:
  - IDLE: after reset.
  - RUN: accepting events.
  - PUSH2: second push of a divergent branch.
  - POP: restoring a stacked context.
  - ERR: terminal until `rst`.
- Internal registers: `cur_pc`, `cur_mask`, `cur_rpc`.
- Stack entry format: `{rpc, pc, mask}`.
- IDLE with `start`: `cur_pc←start_pc`, `cur_mask←start_mask`, `cur_rpc←all-ones`, then go to RUN. Events are ignored in IDLE.
- RUN, accepted step: `nxt_pc = ev_pc`. Mask is unchanged.
- RUN, accepted branch: compute `t = cur_mask & ev_taken_mask` and `n = cur_mask & ~ev_taken_mask`.
  - `n==0`: `nxt_pc = ev_target_pc`.
  - `t==0`: `nxt_pc = ev_pc`.
  - Neither zero (divergent):
    - If `depth > DEPTH-2`: set `ovf←1`, go to ERR. No push; the current context is frozen.
    - Otherwise, this cycle push A = `{cur_rpc, ev_reconv_pc, cur_mask}`.
    - Set `cur←{ev_target_pc, t, ev_reconv_pc}`.
    - Latch `n`, `ev_pc`, `ev_reconv_pc`. Increment `div_count`. Go to PUSH2.
- PUSH2: push B = `{ev_reconv_pc_latched, fall_latched, n_latched}`.
  - If `cur_pc == cur_rpc`, go to POP (target equals reconv: empty taken path).
  - Otherwise go to RUN.
- Non-divergent RUN update: `cur_pc←nxt_pc`. If `nxt_pc == cur_rpc` and `depth>0`, go to POP; otherwise stay in RUN.
- POP: `cur←top`, `depth−1`.
  - If `top.pc == top.rpc` and `depth−1 > 0`, stay in POP (chained reconvergence).
  - Otherwise go to RUN.
- Reconvergence compare uses full PC_W equality. The all-ones sentinel is never popped against because `depth==0` at the outermost level.

## Timing
- Reset values: state IDLE, `cur_valid=0`, `cur_pc=0`, `cur_mask=0`, `depth=0`, `ovf=0`, `div_count=0`, `ev_ready=0`. Stack contents don't-care.
- `ev_ready = (state==RUN)`, combinational from the state register.
- All outputs are registered. A context update is visible the cycle after the event's accepting edge.
- Latency per event type:
  - Uniform branch or step: 1 cycle.
  - Divergent branch: 2 cycles (RUN→PUSH2→RUN), `ev_ready` low for 1 cycle.
  - Each pop adds 1 cycle with `ev_ready` low.
- `depth` counts push A on the accept edge and push B on the PUSH2 edge.
- Simultaneous `start` and `ev_valid` in RUN: `start` is ignored.
- `rst` mid-PUSH2 or mid-POP: immediate return to reset values. Partial pushes are discarded.
- `div_count` saturates at 2^CNT_W−1. No wrap.

## Structure
- Package `simt_pkg`: the entry typedef `{rpc, pc, mask}`, the state enum, and the `RPC_NONE` (all-ones) constant.
- Sub-module `simt_ctx_stack`: a DEPTH×entry LIFO.
  - Synchronous push/pop; pop has priority, though simultaneous use is never generated.
  - Combinational `top` read and `depth` output.
  - The sequencer never pushes when full. The stack asserts on overflow in simulation.

## Test plan
- Uniform branch: `start_pc=0x10`, `mask=FFFFFFFF`, branch `taken=FFFFFFFF`, `target=0x40` → next cycle `cur_pc=0x40`, mask unchanged, `depth=0`, `div_count=0`.
- If/else divergence: `taken=0000FFFF`, `target=0x20`, `fall=0x14`, `reconv=0x30`.
  - Expect `cur=(0x20,0000FFFF)`, `ev_ready` low 1 cycle, `depth=2`.
  - Step to 0x30 → POP → `cur=(0x14,FFFF0000)`.
  - Step to 0x30 → POP → `cur=(0x30,FFFFFFFF)`, `depth=0`.
- Empty taken path: divergent branch with `target=reconv=0x30` → PUSH2 then POP.
  - `cur=(fall, not-taken mask)` 3 cycles after accept, `depth=1`.
- Nested divergence, three levels, with distinct reconv PCs → `depth=6`. Unwinding restores each level's mask in LIFO order and ends with `depth=0`.
- Overflow: with `DEPTH=8`, four nested divergent branches, then a fifth divergent branch → `ovf=1`, state ERR, `ev_ready=0`, `cur` unchanged, `depth=8`. `rst` clears everything.
- Reset asserted in PUSH2 → next cycle: all outputs at reset values, `ev_ready=0`.

Source files
------------

// File: rtl/simt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simt_pkg
// Brief    : Shared types and constants for the SIMT branch sequencer:
//            context-stack entry layout, FSM state encodings, RPC sentinel.
// Revision : 1.0 - initial release
// ============================================================================
package simt_pkg;

  // Default lane count and PC width; the stack entry layout is built on these
  localparam int SIMT_W    = 32;
  localparam int SIMT_PC_W = 16;

  // One saved warp context: reconvergence PC, resume PC, lane mask
  typedef struct packed {
    logic [SIMT_PC_W-1:0] rpc;
    logic [SIMT_PC_W-1:0] pc;
    logic [SIMT_W-1:0]    mask;
  } simt_entry_t;

  // Sequencer FSM encodings
  typedef logic [2:0] simt_state_t;
  localparam simt_state_t ST_IDLE  = 3'd0;
  localparam simt_state_t ST_RUN   = 3'd1;
  localparam simt_state_t ST_PUSH2 = 3'd2;
  localparam simt_state_t ST_POP   = 3'd3;
  localparam simt_state_t ST_ERR   = 3'd4;

  // Outermost reconvergence PC: never matched because depth is 0 there
  localparam logic [SIMT_PC_W-1:0] RPC_NONE = '1;

endpackage
`default_nettype wire

// File: rtl/simt_branch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : simt_branch_seq_if
// Brief    : Front-end event / scheduler context bundle of the SIMT branch
//            sequencer. master = warp front end + scheduler, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface simt_branch_seq_if #(
  parameter int W     = 32,
  parameter int PC_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic                       start;
  logic [PC_W-1:0]            start_pc;
  logic [W-1:0]               start_mask;
  logic                       ev_valid;
  logic                       ev_ready;
  logic                       ev_is_br;
  logic [PC_W-1:0]            ev_pc;
  logic [PC_W-1:0]            ev_target_pc;
  logic [PC_W-1:0]            ev_reconv_pc;
  logic [W-1:0]               ev_taken_mask;
  logic                       cur_valid;
  logic [PC_W-1:0]            cur_pc;
  logic [W-1:0]               cur_mask;
  logic [$clog2(DEPTH+1)-1:0] depth;
  logic                       ovf;
  logic [CNT_W-1:0]           div_count;

  modport master (
    output start, start_pc, start_mask, ev_valid, ev_is_br, ev_pc,
           ev_target_pc, ev_reconv_pc, ev_taken_mask,
    input  ev_ready, cur_valid, cur_pc, cur_mask, depth, ovf, div_count
  );

  modport slave (
    input  start, start_pc, start_mask, ev_valid, ev_is_br, ev_pc,
           ev_target_pc, ev_reconv_pc, ev_taken_mask,
    output ev_ready, cur_valid, cur_pc, cur_mask, depth, ovf, div_count
  );
endinterface
`default_nettype wire

// File: rtl/simt_ctx_stack.sv
`default_nettype none
// ============================================================================
// Module   : simt_ctx_stack
// Brief    : DEPTH-entry LIFO of warp contexts. Synchronous push/pop (pop
//            wins), combinational top-of-stack and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module simt_ctx_stack
  import simt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       i_push,
  input  wire logic                       i_pop,
  input  wire simt_entry_t                i_data,
  output      simt_entry_t                o_top,
  output      logic [$clog2(DEPTH+1)-1:0] o_depth
);
  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  simt_entry_t     r_mem [DEPTH];
  logic [DW-1:0]   r_cnt;

  // Occupancy and storage; contents are not reset, only the count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_pop) begin
      r_cnt <= r_cnt - DW'(1);
    end else if (i_push) begin
      r_mem[AW'(r_cnt)] <= i_data;
      r_cnt             <= r_cnt + DW'(1);
    end
  end

  // The sequencer must never push into a full stack or pop an empty one
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(i_push && !i_pop && r_cnt == DW'(DEPTH)));
      assert (!(i_pop && r_cnt == '0));
    end
  end

  assign o_top   = r_mem[AW'(r_cnt - DW'(1))];
  assign o_depth = r_cnt;

endmodule
`default_nettype wire

// File: rtl/simt_branch_seq.sv
`default_nettype none
// ============================================================================
// Module   : simt_branch_seq
// Brief    : Per-warp SIMT branch sequencer. Tracks (pc, mask, rpc) of the
//            warp, splits divergent branches into two stacked contexts and
//            pops them back at reconvergence points.
// Revision : 1.0 - initial release
// ============================================================================
module simt_branch_seq
  import simt_pkg::*;
#(
  parameter int W     = SIMT_W,     // must match the package entry layout
  parameter int PC_W  = SIMT_PC_W,  // must match the package entry layout
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input wire logic          clk,
  input wire logic          rst,
  simt_branch_seq_if.slave  bus
);
  localparam int DW = $clog2(DEPTH+1);

  simt_state_t     r_state;
  logic [PC_W-1:0] r_pc;
  logic [W-1:0]    r_mask;
  logic [PC_W-1:0] r_rpc;
  logic [W-1:0]    r_n_lat;
  logic [PC_W-1:0] r_fall_lat;
  logic [PC_W-1:0] r_rc_lat;
  logic            r_ovf;
  logic [CNT_W-1:0] r_div;

  logic [W-1:0]    w_t;
  logic [W-1:0]    w_n;
  logic            w_accept;
  logic            w_div;
  logic            w_no_room;
  logic [PC_W-1:0] w_nxt_pc;
  logic            w_push;
  logic            w_pop;
  simt_entry_t     w_push_data;
  simt_entry_t     w_top;
  logic [DW-1:0]   w_depth;

  // Event decode: lane split, uniform next PC, push source selection
  always_comb begin
    w_t         = r_mask & bus.ev_taken_mask;
    w_n         = r_mask & ~bus.ev_taken_mask;
    w_accept    = bus.ev_valid && (r_state == ST_RUN);
    w_div       = bus.ev_is_br && (w_t != '0) && (w_n != '0);
    // A divergent branch needs two free slots (A now, B next cycle)
    w_no_room   = w_depth > DW'(DEPTH-2);
    w_nxt_pc    = bus.ev_pc;
    if (bus.ev_is_br && (w_n == '0)) begin
      w_nxt_pc = bus.ev_target_pc;
    end
    w_pop       = (r_state == ST_POP);
    w_push      = (w_accept && w_div && !w_no_room) || (r_state == ST_PUSH2);
    w_push_data = '{rpc: r_rpc, pc: bus.ev_reconv_pc, mask: r_mask};
    if (r_state == ST_PUSH2) begin
      w_push_data = '{rpc: r_rc_lat, pc: r_fall_lat, mask: r_n_lat};
    end
  end

  // Sequencer FSM and current-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_mask     <= '0;
      r_rpc      <= RPC_NONE;
      r_n_lat    <= '0;
      r_fall_lat <= '0;
      r_rc_lat   <= '0;
      r_ovf      <= 1'b0;
      r_div      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pc    <= bus.start_pc;
            r_mask  <= bus.start_mask;
            r_rpc   <= RPC_NONE;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_div) begin
              if (w_no_room) begin
                r_ovf   <= 1'b1;
                r_state <= ST_ERR;
              end else begin
                // Taken lanes run first; fall-through context stacked in PUSH2
                r_pc       <= bus.ev_target_pc;
                r_mask     <= w_t;
                r_rpc      <= bus.ev_reconv_pc;
                r_n_lat    <= w_n;
                r_fall_lat <= bus.ev_pc;
                r_rc_lat   <= bus.ev_reconv_pc;
                if (r_div != '1) begin
                  r_div <= r_div + CNT_W'(1);
                end
                r_state    <= ST_PUSH2;
              end
            end else begin
              r_pc <= w_nxt_pc;
              if ((w_nxt_pc == r_rpc) && (w_depth != '0)) begin
                r_state <= ST_POP;
              end
            end
          end
        end
        ST_PUSH2: begin
          // Target already at reconvergence means the taken path is empty
          r_state <= (r_pc == r_rpc) ? ST_POP : ST_RUN;
        end
        ST_POP: begin
          r_pc   <= w_top.pc;
          r_mask <= w_top.mask;
          r_rpc  <= w_top.rpc;
          r_state <= ((w_top.pc == w_top.rpc) && (w_depth > DW'(1))) ? ST_POP : ST_RUN;
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  simt_ctx_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_top   (w_top),
    .o_depth (w_depth)
  );

  assign bus.ev_ready  = (r_state == ST_RUN);
  assign bus.cur_valid = (r_state == ST_RUN);
  assign bus.cur_pc    = r_pc;
  assign bus.cur_mask  = r_mask;
  assign bus.depth     = w_depth;
  assign bus.ovf       = r_ovf;
  assign bus.div_count = r_div;

endmodule
`default_nettype wire
